// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the byte-enable dual-port RAM.
`default_nettype none

package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

`default_nettype wire

// File: rtl/ram_init_ctrl.sv
// ram_init_ctrl: zero-fill sequencer; walks every word once after reset or clear_req.
`default_nettype none

module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              init_busy,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_state_t        r_state;
  ram_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLEAR: begin
        // A new request mid-fill starts the sweep over from word 0.
        if (clear_req) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LAST_ADDR) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IDLE: begin
        if (clear_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    init_busy = (r_state == CLEAR);
    fill_we   = (r_state == CLEAR);
    fill_addr = r_cnt;
  end

endmodule

`default_nettype wire

// File: rtl/ram_dp_be.sv
// ram_dp_be: simple-dual-port RAM with byte enables, registered reads,
// selectable read-during-write behaviour and a zero-fill engine.
`default_nettype none

module ram_dp_be
  import ram_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int DEPTH    = 1024,
  parameter  int RD_LAT   = 1,
  parameter  int RDW_MODE = RDW_OLD,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                clear_req,
  output logic                init_busy
);

  localparam int                NBYTES  = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);

  if (DATA_W % 8 != 0) begin : g_chk_data_w
    $fatal(1, "ram_dp_be: DATA_W must be a multiple of 8");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_chk_rd_lat
    $fatal(1, "ram_dp_be: RD_LAT must be 1 or 2");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_chk_rdw
    $fatal(1, "ram_dp_be: RDW_MODE must be 0 or 1");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              w_busy;
  logic              w_fill_we;
  logic [ADDR_W-1:0] w_fill_addr;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_rd_in_range;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_rd_next;
  logic [DATA_W-1:0] r_data1;
  logic              r_valid1;

  ram_init_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .init_busy (w_busy),
    .fill_we   (w_fill_we),
    .fill_addr (w_fill_addr)
  );

  assign init_busy     = w_busy;
  assign w_wr_acc      = !w_busy && wr_en && ({1'b0, wr_addr} < DEPTH_W);
  assign w_rd_acc      = !w_busy && rd_en;
  assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign w_rd_word     = mem[rd_addr];

  // Fill port owns the array while busy; user writes are only accepted when idle.
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      mem[w_fill_addr] <= '0;
    end else if (w_wr_acc) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_rd_next = '0;
    if (w_rd_in_range) begin
      w_rd_next = w_rd_word;
      if (RDW_MODE == RDW_NEW && w_wr_acc && (wr_addr == rd_addr)) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (wr_be[b]) begin
            w_rd_next[8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data1  <= '0;
      r_valid1 <= 1'b0;
    end else begin
      r_valid1 <= w_rd_acc;
      if (w_rd_acc) begin
        r_data1 <= w_rd_next;
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] r_data2;
    logic              r_valid2;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_data2  <= '0;
        r_valid2 <= 1'b0;
      end else begin
        r_valid2 <= r_valid1;
        if (r_valid1) begin
          r_data2 <= r_data1;
        end
      end
    end

    assign rd_data  = r_data2;
    assign rd_valid = r_valid2;
  end else begin : g_lat1
    assign rd_data  = r_data1;
    assign rd_valid = r_valid1;
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: two DUT configurations driven in lockstep against a reference model.
`default_nettype none

module tb_ram_dp_be;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic        clear_req;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic        init_busy_a, init_busy_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Index 0: DEPTH 1024, RD_LAT 1, old-data RDW. Index 1: DEPTH 1000, RD_LAT 2, new-data RDW.
  int          c_depth [2] = '{1024, 1000};
  int          c_lat   [2] = '{1, 2};
  int          c_mode  [2] = '{0, 1};
  logic [31:0] mdl_mem [2][1024];
  int          busy_left [2];
  logic [31:0] last_d [2];
  rd_t         pq0[$];
  rd_t         pq1[$];

  ram_dp_be #(.DATA_W(32), .DEPTH(1024), .RD_LAT(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .clear_req(clear_req), .init_busy(init_busy_a)
  );

  ram_dp_be #(.DATA_W(32), .DEPTH(1000), .RD_LAT(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .clear_req(clear_req), .init_busy(init_busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 1024; a++) mdl_mem[k][a] = '0;
      busy_left[k] = c_depth[k];
      last_d[k]    = '0;
    end
    pq0.delete();
    pq1.delete();
  endtask

  task automatic check_outputs();
    logic [31:0] od;
    logic        ov, ob;
    rd_t         e;
    bit          ev;
    for (int k = 0; k < 2; k++) begin
      od = (k == 0) ? rd_data_a   : rd_data_b;
      ov = (k == 0) ? rd_valid_a  : rd_valid_b;
      ob = (k == 0) ? init_busy_a : init_busy_b;
      chk($sformatf("busy%0d", k), {31'd0, ob}, {31'd0, busy_left[k] != 0});
      ev = 1'b0;
      if (k == 0 && pq0.size() > 0 && pq0[0].due == cyc) begin e = pq0.pop_front(); ev = 1'b1; end
      if (k == 1 && pq1.size() > 0 && pq1[0].due == cyc) begin e = pq1.pop_front(); ev = 1'b1; end
      chk($sformatf("valid%0d", k), {31'd0, ov}, {31'd0, ev});
      if (ev) last_d[k] = e.data;
      chk($sformatf("data%0d", k), od, last_d[k]);
    end
  endtask

  task automatic step(input bit we, input int wa, input logic [31:0] wd, input logic [3:0] be,
                      input bit re, input int ra, input bit clr);
    rd_t         r;
    logic [31:0] w;
    wr_en = we; wr_addr = 10'(wa); wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = 10'(ra); clear_req = clr;
    for (int k = 0; k < 2; k++) begin
      if (busy_left[k] == 0) begin
        if (re) begin
          w = 32'd0;
          if (ra < c_depth[k]) begin
            w = mdl_mem[k][ra];
            if (c_mode[k] == 1 && we && wa == ra)
              for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
          end
          r.due = cyc + c_lat[k];
          r.data = w;
          if (k == 0) pq0.push_back(r); else pq1.push_back(r);
        end
        if (we && wa < c_depth[k])
          for (int b = 0; b < 4; b++) if (be[b]) mdl_mem[k][wa][8*b +: 8] = wd[8*b +: 8];
        if (clr) begin
          busy_left[k] = c_depth[k];
          for (int a = 0; a < 1024; a++) mdl_mem[k][a] = '0;
        end
      end else begin
        busy_left[k] = clr ? c_depth[k] : busy_left[k] - 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'd0, 4'h0, 0, 0, 0);
  endtask

  initial begin
    int wa, ra;
    reset = 1'b1;
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 0; rd_addr = '0; clear_req = 0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_valid_a", {31'd0, rd_valid_a}, 32'd0);
    chk("rst_valid_b", {31'd0, rd_valid_b}, 32'd0);
    chk("rst_data_a", rd_data_a, 32'd0);
    chk("rst_data_b", rd_data_b, 32'd0);
    chk("rst_busy_a", {31'd0, init_busy_a}, 32'd1);
    chk("rst_busy_b", {31'd0, init_busy_b}, 32'd1);

    // Fill after reset: busy for exactly DEPTH cycles, then every word reads 0
    reset = 1'b0;
    idle(1030);
    for (int a = 0; a < 1024; a++) step(0, 0, 32'd0, 4'h0, 1, a, 0);
    idle(3);

    // Byte enables on addr 5, then three back-to-back reads
    step(1, 5, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    step(1, 5, 32'h11223344, 4'b0101, 0, 0, 0);
    step(0, 0, 32'd0, 4'h0, 1, 5, 0);
    step(0, 0, 32'd0, 4'h0, 1, 5, 0);
    step(0, 0, 32'd0, 4'h0, 1, 5, 0);
    idle(3);

    // Read-during-write on addr 7
    step(1, 7, 32'hFFFF0000, 4'hC, 1, 7, 0);
    step(0, 0, 32'd0, 4'h0, 1, 7, 0);
    idle(3);

    // Out-of-range write/read for the 1000-deep instance
    step(1, 999, 32'h5A5A1234, 4'hF, 0, 0, 0);
    step(1, 1010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    step(0, 0, 32'd0, 4'h0, 1, 1010, 0);
    step(0, 0, 32'd0, 4'h0, 1, 999, 0);
    idle(3);

    // Clear with a write and a read issued while busy
    for (int a = 0; a < 4; a++) step(1, a, $urandom, 4'hF, 0, 0, 0);
    step(0, 0, 32'd0, 4'h0, 1, 2, 1);
    step(1, 3, 32'hCAFEF00D, 4'hF, 1, 3, 0);
    idle(1030);
    for (int a = 0; a < 4; a++) step(0, 0, 32'd0, 4'h0, 1, a, 0);
    idle(3);

    // Randomized traffic with a bias toward collisions and out-of-range addresses
    for (int i = 0; i < 400; i++) begin
      wa = ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 15);
      ra = ($urandom_range(0, 2) == 0) ? wa :
           (($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 15));
      step($urandom_range(0, 1), wa, $urandom, 4'($urandom), $urandom_range(0, 1), ra, 0);
    end

    // Asynchronous reset with reads in flight
    step(0, 0, 32'd0, 4'h0, 1, 3, 0);
    step(0, 0, 32'd0, 4'h0, 1, 4, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_valid_a", {31'd0, rd_valid_a}, 32'd0);
    chk("async_valid_b", {31'd0, rd_valid_b}, 32'd0);
    chk("async_busy_a", {31'd0, init_busy_a}, 32'd1);
    chk("async_data_b", rd_data_b, 32'd0);
    model_reset();
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    idle(1030);
    for (int a = 0; a < 8; a++) step(0, 0, 32'd0, 4'h0, 1, a, 0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
